// File: rtl/frame_min_max_tracker_pkg.sv
// Shared types and helpers for the frame min/max tracker and its comparator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package frame_tracker_pkg;

   // Result of one unsigned magnitude compare of a against b
   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_res_t;

   // Frame reduction state machine
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   // Index width for n entries; never narrower than one bit so a
   // single-sample frame still has a legal index port.
   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/frame_min_max_tracker_mag_cmp.sv
// Unsigned WIDTH-bit magnitude comparator producing lt/eq/gt of a versus b.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module mag_cmp
   import frame_tracker_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_res_t         res
);

   // Full-width unsigned compare; exactly one flag is set for any input pair
   always_comb begin
      res.lt = (a < b);
      res.eq = (a == b);
      res.gt = (a > b);
   end

endmodule

// File: rtl/frame_min_max_tracker.sv
// Reduces each frame of unsigned samples to min, max, first-occurrence indices and count.
// Latency: result valid 1 cycle after the closing sample is accepted; one bubble per frame.
// Backpressure: in_ready drops while a result waits; result held stable until out_ready.
// Optional build macro FRAME_THRESH_CNT_EN adds thresh input and out_above_cnt output.
module frame_min_max_tracker
   import frame_tracker_pkg::*;
#(
   parameter int  WIDTH     = 4,
   parameter int  FRAME_MAX = 8,
   localparam int IDXW      = clog2_min1(FRAME_MAX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_last,
`ifdef FRAME_THRESH_CNT_EN
   input  logic [WIDTH-1:0]  thresh,
   output logic [IDXW:0]     out_above_cnt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_min,
   output logic [WIDTH-1:0]  out_max,
   output logic [IDXW-1:0]   out_min_idx,
   output logic [IDXW-1:0]   out_max_idx,
   output logic [IDXW:0]     out_cnt,
   output logic              out_all_eq
);

   // Count value of the last sample slot; accepting while here auto-closes the frame
   localparam logic [IDXW:0] CNT_LAST = (IDXW+1)'(FRAME_MAX - 1);

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [WIDTH-1:0]  min_q, min_d;
   logic [WIDTH-1:0]  max_q, max_d;
   logic [IDXW-1:0]   min_idx_q, min_idx_d;
   logic [IDXW-1:0]   max_idx_q, max_idx_d;
   logic [IDXW:0]     cnt_q, cnt_d;

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_min_q, out_min_d;
   logic [WIDTH-1:0]  out_max_q, out_max_d;
   logic [IDXW-1:0]   out_min_idx_q, out_min_idx_d;
   logic [IDXW-1:0]   out_max_idx_q, out_max_idx_d;
   logic [IDXW:0]     out_cnt_q, out_cnt_d;
   logic              out_all_eq_q, out_all_eq_d;

   logic              accept;
   logic              close;
   logic [IDXW-1:0]   cur_idx;
   cmp_res_t          cmp_min;
   cmp_res_t          cmp_max;
   logic              unused_cmp_bits;

   assign accept  = in_valid && in_ready_q;
   // In ACCUM the running count is also the index of the incoming sample
   assign cur_idx = cnt_q[IDXW-1:0];

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
      .a   (in_data),
      .b   (min_q),
      .res (cmp_min)
   );

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
      .a   (in_data),
      .b   (max_q),
      .res (cmp_max)
   );

   // Only lt matters against min and gt against max; ties keep the first occurrence
   assign unused_cmp_bits = ^{cmp_min.eq, cmp_min.gt, cmp_max.lt, cmp_max.eq};

   // Next-state: frame accumulation, close detection and result capture
   always_comb begin
      state_d       = state_q;
      min_d         = min_q;
      max_d         = max_q;
      min_idx_d     = min_idx_q;
      max_idx_d     = max_idx_q;
      cnt_d         = cnt_q;
      close         = 1'b0;
      out_valid_d   = out_valid_q;
      out_min_d     = out_min_q;
      out_max_d     = out_max_q;
      out_min_idx_d = out_min_idx_q;
      out_max_idx_d = out_max_idx_q;
      out_cnt_d     = out_cnt_q;
      out_all_eq_d  = out_all_eq_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               min_d     = in_data;
               max_d     = in_data;
               min_idx_d = '0;
               max_idx_d = '0;
               cnt_d     = (IDXW+1)'(1);
               close     = in_last || (FRAME_MAX == 1);
               state_d   = close ? OUT : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (cmp_min.lt) begin
                  min_d     = in_data;
                  min_idx_d = cur_idx;
               end
               if (cmp_max.gt) begin
                  max_d     = in_data;
                  max_idx_d = cur_idx;
               end
               cnt_d   = cnt_q + 1'b1;
               close   = in_last || (cnt_q == CNT_LAST);
               state_d = close ? OUT : ACCUM;
            end
         end
         OUT: begin
            if (out_valid_q && out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Snapshot the finished frame into the output registers
      if (close) begin
         out_valid_d   = 1'b1;
         out_min_d     = min_d;
         out_max_d     = max_d;
         out_min_idx_d = min_idx_d;
         out_max_idx_d = max_idx_d;
         out_cnt_d     = cnt_d;
         out_all_eq_d  = (min_d == max_d);
      end

      // Ready tracks the state being entered so it returns together with IDLE
      in_ready_d = (state_d != OUT);
   end

   // State and working registers; reset discards any partial frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         min_q      <= '0;
         max_q      <= '0;
         min_idx_q  <= '0;
         max_idx_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         min_q      <= min_d;
         max_q      <= max_d;
         min_idx_q  <= min_idx_d;
         max_idx_q  <= max_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   // Result registers, held stable while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_min_q     <= '0;
         out_max_q     <= '0;
         out_min_idx_q <= '0;
         out_max_idx_q <= '0;
         out_cnt_q     <= '0;
         out_all_eq_q  <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_min_q     <= out_min_d;
         out_max_q     <= out_max_d;
         out_min_idx_q <= out_min_idx_d;
         out_max_idx_q <= out_max_idx_d;
         out_cnt_q     <= out_cnt_d;
         out_all_eq_q  <= out_all_eq_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_min     = out_min_q;
   assign out_max     = out_max_q;
   assign out_min_idx = out_min_idx_q;
   assign out_max_idx = out_max_idx_q;
   assign out_cnt     = out_cnt_q;
   assign out_all_eq  = out_all_eq_q;

`ifdef FRAME_THRESH_CNT_EN
   logic [WIDTH-1:0] thresh_q, thresh_d;
   logic [WIDTH-1:0] thr_sel;
   logic [IDXW:0]    above_q, above_d;
   logic [IDXW:0]    out_above_q, out_above_d;
   cmp_res_t         cmp_thr;
   logic             unused_thr_bits;

   // First sample of a frame compares against the live threshold it latches
   assign thr_sel = (state_q == IDLE) ? thresh : thresh_q;

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_thr (
      .a   (in_data),
      .b   (thr_sel),
      .res (cmp_thr)
   );

   assign unused_thr_bits = ^{cmp_thr.lt, cmp_thr.eq};

   // Count samples strictly above the frame threshold and capture at close
   always_comb begin
      thresh_d    = thresh_q;
      above_d     = above_q;
      out_above_d = out_above_q;
      if (accept) begin
         if (state_q == IDLE) begin
            thresh_d = thresh;
            above_d  = {{IDXW{1'b0}}, cmp_thr.gt};
         end else begin
            above_d  = above_q + {{IDXW{1'b0}}, cmp_thr.gt};
         end
      end
      if (close) begin
         out_above_d = above_d;
      end
   end

   // Threshold latch, running count and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thresh_q    <= '0;
         above_q     <= '0;
         out_above_q <= '0;
      end else begin
         thresh_q    <= thresh_d;
         above_q     <= above_d;
         out_above_q <= out_above_d;
      end
   end

   assign out_above_cnt = out_above_q;
`endif

endmodule
